// File: rtl/freq_meas_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_meas_ctrl
// Description : Measurement sequencer around freq_detector (adc_clk domain).
//               Clears the detector, waits for lock (with timeout), averages
//               2^AVG_LOG2 period readings, and auto-ranges the ADC
//               decimation select until the average lands in the window.
//               Results are reported as a one-cycle strobe with the period
//               rescaled to undecimated adc_clk samples, plus status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meas_ctrl #(
  parameter int PW              = 12,
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_GAP      = 64,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int CLR_CYCLES      = 4,
  parameter int PER_LO          = 64,
  parameter int PER_HI          = 2048,
  parameter int MAX_RANGE_STEPS = 4
) (
  input  logic          adc_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          det_stable,
  input  logic [PW-1:0] det_period,
  output logic          det_clr,
  output logic [1:0]    decim_sel,
  output logic          busy,
  output logic          result_valid,
  output logic [PW+2:0] result_period,
  output logic          timeout,
  output logic          range_err
);

  // --------------------------------------------------------------------------
  // Derived sizes and typed constants
  // --------------------------------------------------------------------------
  localparam int c_n      = 1 << AVG_LOG2;
  localparam int c_acc_w  = PW + AVG_LOG2;
  localparam int c_res_w  = PW + 3;
  localparam int c_clr_w  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int c_wait_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_gap_w  = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int c_samp_w = AVG_LOG2 + 1;
  localparam int c_step_w = $clog2(MAX_RANGE_STEPS + 1);

  localparam logic [c_clr_w-1:0]  c_clr_last  = c_clr_w'(CLR_CYCLES - 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(SAMPLE_GAP - 1);
  localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'(c_n - 1);
  localparam logic [c_step_w-1:0] c_step_max  = c_step_w'(MAX_RANGE_STEPS);
  localparam logic [PW-1:0]       c_per_lo    = PW'(PER_LO);
  localparam logic [PW-1:0]       c_per_hi    = PW'(PER_HI);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RANGE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and combinational helpers
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_next;
  logic [c_clr_w-1:0]    r_clr_cnt;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic [c_gap_w-1:0]    r_gap_cnt;
  logic [c_samp_w-1:0]   r_samp_cnt;
  logic [c_acc_w-1:0]    r_acc;
  logic [1:0]            r_decim;
  logic [c_step_w-1:0]   r_steps;
  logic [c_res_w-1:0]    r_result;
  logic                  r_timeout;
  logic                  r_range_err;

  logic [PW-1:0]         w_avg;
  logic [c_res_w-1:0]    w_avg_ext;
  logic [c_res_w-1:0]    w_scaled;
  logic                  w_above;
  logic                  w_below;
  logic                  w_can_step;
  logic                  w_step_up;
  logic                  w_step_dn;
  logic                  w_sample;
  logic                  w_last_sample;
  logic                  w_wait_expire;

  // Average is a plain truncating shift; the accumulator is sized so the
  // sum of N full-scale readings never overflows.
  assign w_avg      = r_acc[c_acc_w-1:AVG_LOG2];
  assign w_avg_ext  = {3'b000, w_avg};
  assign w_scaled   = w_avg_ext << r_decim;
  assign w_above    = (w_avg > c_per_hi);
  assign w_below    = (w_avg < c_per_lo);
  assign w_can_step = (r_steps < c_step_max);
  assign w_step_up  = w_above && (r_decim != 2'd3) && w_can_step;
  assign w_step_dn  = w_below && (r_decim != 2'd0) && w_can_step;

  // A reading is only taken on a sampling slot while the detector is locked;
  // a slot with det_stable low aborts the capture instead.
  assign w_sample      = (r_state == ST_CAPTURE) && det_stable && (r_gap_cnt == '0);
  assign w_last_sample = w_sample && (r_samp_cnt == c_samp_last);
  assign w_wait_expire = (r_state == ST_WAIT) && !det_stable && (r_wait_cnt == c_wait_last);

  assign decim_sel     = r_decim;
  assign result_period = r_result;
  assign timeout       = r_timeout;
  assign range_err     = r_range_err;

  // State register
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next       = r_state;
    det_clr      = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        det_clr = 1'b1;
        if (r_clr_cnt == c_clr_last) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (det_stable) begin
          w_next = ST_CAPTURE;
        end else if (r_wait_cnt == c_wait_last) begin
          w_next = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        if (!det_stable) begin
          w_next = ST_WAIT;
        end else if (w_last_sample) begin
          w_next = ST_RANGE;
        end
      end
      ST_RANGE: begin
        if (w_step_up || w_step_dn) begin
          w_next = ST_CLEAR;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        w_next       = continuous ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Per-state cycle counters; each restarts from zero whenever its state is
  // (re)entered because it is held at zero outside that state.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_clr_cnt  <= '0;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if ((r_state == ST_CLEAR) && (w_next == ST_CLEAR)) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end else begin
        r_clr_cnt <= '0;
      end

      if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if ((r_state == ST_CAPTURE) && (w_next == ST_CAPTURE)) begin
        r_gap_cnt <= (r_gap_cnt == c_gap_last) ? '0 : r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // Reading accumulator; emptied while clearing or waiting for lock so an
  // aborted capture never mixes with the next one.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_samp_cnt <= '0;
    end else if (w_sample) begin
      r_acc      <= r_acc + c_acc_w'(det_period);
      r_samp_cnt <= r_samp_cnt + 1'b1;
    end else if ((r_state == ST_CLEAR) || (r_state == ST_WAIT)) begin
      r_acc      <= '0;
      r_samp_cnt <= '0;
    end
  end

  // Auto-ranging and result/flag capture; results are loaded on the edge
  // into DONE so they are already valid while result_valid is high.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      r_decim     <= 2'd0;
      r_steps     <= '0;
      r_result    <= '0;
      r_timeout   <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if (((r_state == ST_IDLE) && start) || ((r_state == ST_DONE) && continuous)) begin
        r_steps <= '0;
      end

      if (r_state == ST_RANGE) begin
        if (w_step_up) begin
          r_decim <= r_decim + 2'd1;
          r_steps <= r_steps + 1'b1;
        end else if (w_step_dn) begin
          r_decim <= r_decim - 2'd1;
          r_steps <= r_steps + 1'b1;
        end else begin
          r_result    <= w_scaled;
          r_timeout   <= 1'b0;
          r_range_err <= w_above || w_below;
        end
      end

      if (w_wait_expire) begin
        r_result    <= '0;
        r_timeout   <= 1'b1;
        r_range_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_freq_meas_ctrl
// Description : Scoreboard bench for freq_meas_ctrl with a behavioural
//               freq_detector model (locks 10 cycles after clear).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meas_ctrl;
  localparam int PW = 12;

  logic          adc_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          det_stable;
  logic [PW-1:0] det_period;
  logic          det_clr;
  logic [1:0]    decim_sel;
  logic          busy;
  logic          result_valid;
  logic [PW+2:0] result_period;
  logic          timeout;
  logic          range_err;

  freq_meas_ctrl #(
    .PW(PW), .AVG_LOG2(2), .SAMPLE_GAP(64), .TIMEOUT_CYCLES(256),
    .CLR_CYCLES(4), .PER_LO(64), .PER_HI(2048), .MAX_RANGE_STEPS(4)
  ) dut (
    .adc_clk(adc_clk), .rst(rst), .start(start), .continuous(continuous),
    .det_stable(det_stable), .det_period(det_period), .det_clr(det_clr),
    .decim_sel(decim_sel), .busy(busy), .result_valid(result_valid),
    .result_period(result_period), .timeout(timeout), .range_err(range_err)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge adc_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Detector model controls
  int base_per     = 1000;
  bit fixed_mode   = 1'b0;
  bit kill         = 1'b0;
  bit never_stable = 1'b0;
  int settle       = 0;
  int clr_len      = 0;
  int clr_pulses   = 0;
  int clr_fall_cyc = 0;
  int rise_cyc     = 0;
  int rise_cnt     = 0;
  bit prev_clr     = 1'b0;

  // Detector model: lock 10 cycles after det_clr falls, period follows decimation
  initial begin
    bit nxt;
    det_stable = 1'b0;
    det_period = '0;
    forever begin
      @(negedge adc_clk);
      if (det_clr === 1'b1) settle = 0;
      else if (settle < 10) settle++;
      nxt = (settle >= 10) && !kill && !never_stable;
      if (nxt && !det_stable) begin
        rise_cyc = cyc;
        rise_cnt++;
      end
      det_stable = nxt;
      det_period = fixed_mode ? PW'(base_per) : PW'(base_per >> decim_sel);
      if (det_clr === 1'b1) begin
        clr_len++;
      end else if (prev_clr) begin
        check("det_clr_len", clr_len, 4);
        clr_len = 0;
        clr_pulses++;
        clr_fall_cyc = cyc;
      end
      prev_clr = (det_clr === 1'b1);
    end
  end

  // Scoreboard
  typedef struct {
    int per;
    int to;
    int re;
    int dec;
  } exp_t;
  exp_t exp_q[$];
  int n_results     = 0;
  int last_res_cyc  = 0;
  int last_res_busy = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge adc_clk);
      if (result_valid === 1'b1) begin
        n_results++;
        last_res_cyc  = cyc;
        last_res_busy = int'(busy);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got period %0d with no result expected (cycle %0d)",
                   result_period, cyc);
        end else begin
          e = exp_q.pop_front();
          check("result_period", int'(result_period), e.per);
          check("timeout", int'(timeout), e.to);
          check("range_err", int'(range_err), e.re);
          check("decim_sel", int'(decim_sel), e.dec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic expect_result(input int per, input int to, input int re, input int dec);
    exp_t e;
    e.per = per; e.to = to; e.re = re; e.dec = dec;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_results(input int target, input int budget, input string name);
    int k = 0;
    while (n_results < target && k < budget) begin
      tick();
      k++;
    end
    if (n_results < target) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d results expected %0d within %0d cycles", name, n_results, target, budget);
    end
  endtask

  task automatic wait_rise(input int prev, output int s);
    int k = 0;
    while (rise_cnt == prev && k < 500) begin
      tick();
      k++;
    end
    if (rise_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL stable_rise: got no det_stable rise expected one within 500 cycles");
    end
    s = rise_cyc;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected one before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int s, p0, r0, t_first;
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_det_clr", int'(det_clr), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_result_period", int'(result_period), 0);
    check("rst_decim_sel", int'(decim_sel), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_range_err", int'(range_err), 0);

    // Basic measurement, latency from CAPTURE entry
    base_per = 1000; p0 = clr_pulses; r0 = rise_cnt;
    expect_result(1000, 0, 0, 0);
    pulse_start();
    wait_rise(r0, s);
    wait_results(1, 2000, "t1_result");
    check("t1_capture_to_valid", last_res_cyc - (s + 1), 194);
    check("t1_clr_pulses", clr_pulses - p0, 1);
    check("t1_busy_after", int'(busy), 0);

    // One step up in decimation
    base_per = 3000; p0 = clr_pulses;
    expect_result(3000, 0, 0, 1);
    pulse_start();
    wait_results(2, 2000, "t2_result");
    check("t2_clr_pulses", clr_pulses - p0, 2);

    // Reset in the middle of CAPTURE (decim_sel is 1 beforehand)
    r0 = rise_cnt;
    pulse_start();
    wait_rise(r0, s);
    wait_until(s + 50);
    rst = 1'b1;
    tick();
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_det_clr", int'(det_clr), 0);
    check("t6_rst_decim", int'(decim_sel), 0);
    check("t6_rst_valid", int'(result_valid), 0);
    rst = 1'b0;
    repeat (300) tick();
    check("t6_idle_busy", int'(busy), 0);
    check("t6_no_result", n_results, 2);

    // Timeout in WAIT_STABLE
    never_stable = 1'b1;
    expect_result(0, 1, 0, 0);
    pulse_start();
    wait_results(3, 1000, "t3_result");
    check("t3_wait_to_valid", last_res_cyc - clr_fall_cyc, 256);
    check("t3_busy_at_done", last_res_busy, 1);
    check("t3_busy_after", int'(busy), 0);
    never_stable = 1'b0;

    // Lock lost after two readings: no mixing of 500 and 800
    base_per = 500; r0 = rise_cnt;
    expect_result(800, 0, 0, 0);
    pulse_start();
    wait_rise(r0, s);
    wait_until(s + 100);
    kill = 1'b1;
    base_per = 800;
    repeat (5) tick();
    kill = 1'b0;
    wait_results(4, 2000, "t4_result");

    // Truncating average: (100+101+101+101)/4 = 100
    base_per = 100; r0 = rise_cnt;
    expect_result(100, 0, 0, 0);
    pulse_start();
    wait_rise(r0, s);
    wait_until(s + 30);
    base_per = 101;
    wait_results(5, 2000, "t4b_result");

    // Below window at decim 0: no step possible
    base_per = 20; p0 = clr_pulses;
    expect_result(20, 0, 1, 0);
    pulse_start();
    wait_results(6, 2000, "t5a_result");
    check("t5a_clr_pulses", clr_pulses - p0, 1);

    // Constant 4000: steps to decim 3, still out of window
    fixed_mode = 1'b1; base_per = 4000; p0 = clr_pulses;
    expect_result(32000, 0, 1, 3);
    pulse_start();
    wait_results(7, 4000, "t5b_result");
    check("t5b_clr_pulses", clr_pulses - p0, 4);
    fixed_mode = 1'b0;

    // Continuous mode: back-to-back results
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    check("cont_decim_after_rst", int'(decim_sel), 0);
    base_per = 1000; continuous = 1'b1; p0 = clr_pulses;
    expect_result(1000, 0, 0, 0);
    expect_result(1000, 0, 0, 0);
    expect_result(1000, 0, 0, 0);
    pulse_start();
    wait_results(8, 2000, "cont_result1");
    t_first = last_res_cyc;
    wait_results(9, 2000, "cont_result2");
    check("cont_spacing", last_res_cyc - t_first, 209);
    continuous = 1'b0;
    wait_results(10, 2000, "cont_result3");
    check("cont_clr_pulses", clr_pulses - p0, 3);
    check("cont_busy_after", int'(busy), 0);

    // start while busy is ignored and not queued
    expect_result(1000, 0, 0, 0);
    p0 = clr_pulses; r0 = rise_cnt;
    pulse_start();
    wait_rise(r0, s);
    wait_until(s + 40);
    pulse_start();
    wait_results(11, 2000, "busy_start_result");
    repeat (300) tick();
    check("busy_start_clr_pulses", clr_pulses - p0, 1);
    check("busy_start_idle", int'(busy), 0);
    check("busy_start_results", n_results, 11);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer wrapped around freq_detector in the ADC clock domain. On request it clears the detector and waits for its stable flag, with a timeout. It then averages 2^AVG_LOG2 period readings and auto-ranges the ADC decimation select until the reading falls inside [PER_LO, PER_HI]. Each result is reported as a one-cycle result_valid strobe carrying the period scaled back to undecimated adc_clk samples, plus status flags.

Parameters:
PW, 12, width of det_period
AVG_LOG2, 2, log2 of readings averaged per result (N = 4)
SAMPLE_GAP, 64, adc_clk cycles between successive readings in CAPTURE
TIMEOUT_CYCLES, 65536, maximum cycles spent in WAIT_STABLE
CLR_CYCLES, 4, length of the det_clr pulse
PER_LO, 64, lowest accepted averaged period (inclusive)
PER_HI, 2048, highest accepted averaged period (inclusive)
MAX_RANGE_STEPS, 4, maximum decimation changes per measurement

Ports:
adc_clk  in  1  sole clock
rst  in  1  synchronous reset, active-high
start  in  1  measurement request; sampled only in IDLE
continuous  in  1  when 1, DONE restarts automatically instead of returning to IDLE
det_stable  in  1  stable flag from freq_detector
det_period  in  PW  period from freq_detector, unsigned
det_clr  out  1  active-high clear to the detector; top level inverts it onto the detector's rst_n
decim_sel  out  2  ADC decimation select; factor = 2^decim_sel
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle strobe
result_period  out  PW+3  averaged period << decim_sel
timeout  out  1  last result ended in timeout
range_err  out  1  last result is outside the window and could not be corrected

Behaviour:
- Reset: all of the following are 0 at the edge where rst=1: outputs, accumulator, all counters, decim_sel, range step count. State goes to IDLE. rst has priority over everything, including mid-CAPTURE operation.
- States: IDLE, CLEAR, WAIT_STABLE, CAPTURE, RANGE, DONE.
- IDLE: start=1 at an edge -> CLEAR on the next cycle. The range step count is cleared at this point; decim_sel is kept.
- start while busy=1 is ignored and is not queued.
- CLEAR: det_clr=1 for exactly CLR_CYCLES cycles, then WAIT_STABLE. The accumulator and sample count are zeroed on CLEAR entry.
- WAIT_STABLE:
  - The wait counter starts at 0 on entry.
  - det_stable=1 -> CAPTURE next cycle.
  - The counter reaching TIMEOUT_CYCLES-1 with det_stable=0 -> DONE with timeout=1, result_period=0. decim_sel is unchanged.
- CAPTURE:
  - The first reading is taken in the first CAPTURE cycle, then one every SAMPLE_GAP cycles.
  - Each reading adds det_period into an accumulator of width PW+AVG_LOG2 (no overflow possible).
  - det_stable=0 in any CAPTURE cycle, including a sampling cycle (no reading taken), -> discard accumulator and sample count, return to WAIT_STABLE, wait counter restarts.
  - After the Nth reading -> RANGE next cycle.
- RANGE (one cycle): avg = accumulator >> AVG_LOG2, truncated.
  - avg > PER_HI, decim_sel < 3, step count < MAX_RANGE_STEPS -> decim_sel+1, step count+1, go to CLEAR.
  - avg < PER_LO, decim_sel > 0, step count < MAX_RANGE_STEPS -> decim_sel-1, step count+1, go to CLEAR.
  - Otherwise -> DONE. range_err=1 only if avg is outside [PER_LO, PER_HI] (boundaries accepted).
- DONE (one cycle):
  - result_valid=1. result_period = avg << decim_sel, zero-extended to PW+3.
  - timeout and range_err are updated in this cycle and held until the next DONE.
  - Next state: continuous=1 -> CLEAR (step count cleared); otherwise IDLE.
- result_period holds its value between strobes.
- Latency from CAPTURE entry to result_valid, when no re-range occurs: (N-1)*SAMPLE_GAP + 2 cycles.

Test Plan:
- start pulse; bench holds det_stable=1 from 10 cycles after det_clr falls, det_period=1000 -> det_clr high 4 cycles; result_valid exactly 194 cycles after CAPTURE entry; result_period=1000, decim_sel=0, flags 0.
- det_period=3000 at decim 0, then model returns 1500 after the re-clear -> one extra det_clr pulse, decim_sel=1, result_period=3000, range_err=0.
- TIMEOUT_CYCLES=256, det_stable held 0 -> result_valid 256 cycles after WAIT_STABLE entry; timeout=1, result_period=0, busy falls the next cycle.
- Readings 500,500, then det_stable drops for 5 cycles, then stable at 800 -> result_period=800 (no mixing); readings 100,101,101,101 -> result 100 (truncation).
- det_period=20 at decim_sel=0 -> no step taken, range_err=1, result 20; det_period=4000 constant -> decim steps 1,2,3, then range_err=1, result_period=32000.
- rst pulsed mid-CAPTURE -> next edge: busy=0, det_clr=0, decim_sel=0, no result_valid. continuous=1 -> back-to-back results, each preceded by a 4-cycle det_clr. start while busy -> no effect.
